// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad front end of the lock.
// State enum, keypad geometry and the row/column to digit encoder.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } kp_state_e;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 3;

  function automatic logic [3:0] key_encode(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] r4;
    logic [3:0] c4;
    r4 = {2'b00, row};
    c4 = {2'b00, col};
    return (r4 << 1) + r4 + c4 + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the three asynchronous column lines.
// Resets to all-high, the idle level of the pulled-up columns.
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_async,
  output logic [2:0] col_sync
);

  logic [2:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 3'b111;
      col_sync <= 3'b111;
    end else begin
      meta     <= col_async;
      col_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 3x3 keypad scanner: row rotation, debounce, encode, valid/ack delivery.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctrl
  import lock_pkg::*;
#(
  parameter int SETTLE_CYC     = 64,
  parameter int DEBOUNCE_CYC   = 240000,
  parameter int REPEAT_DLY_CYC = 6000000,
  parameter int REPEAT_CYC     = 2400000
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       scan_en,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_overrun
);

  localparam int M1 =
    (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int M2 =
    (REPEAT_DLY_CYC > REPEAT_CYC) ? REPEAT_DLY_CYC : REPEAT_CYC;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MAXP) + 1;

  kp_state_e state, state_n;
  logic [1:0]    row_q, row_n;
  logic [1:0]    col_q, col_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]    col_s;
  logic [2:0]    col_low;
  logic [1:0]    hit_col;
  logic [1:0]    row_nxt;
  logic          cur_low;
  logic          any_low;
  logic          accept;
  logic          drive;

  keypad_col_sync u_sync (
    .clk       (hwclk),
    .rst_n     (rst_n),
    .col_async ({keypad_c3, keypad_c2, keypad_c1}),
    .col_sync  (col_s)
  );

  assign col_low = ~col_s;
  assign any_low = |col_low;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign row_nxt = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;

  always_comb begin
    hit_col = 2'd0;
    priority case (1'b1)
      col_low[0]: hit_col = 2'd0;
      col_low[1]: hit_col = 2'd1;
      col_low[2]: hit_col = 2'd2;
      default:    hit_col = 2'd0;
    endcase
  end

  always_comb begin
    cur_low = col_low[2];
    if (col_q == 2'd0) cur_low = col_low[0];
    else if (col_q == 2'd1) cur_low = col_low[1];
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0] rep_cnt, rep_n;
  logic          rep_first, first_n;
  logic          rep_hit;

  assign rep_hit = rep_first
    ? (rep_cnt >= CW'(REPEAT_DLY_CYC - 1))
    : (rep_cnt >= CW'(REPEAT_CYC - 1));

  always_comb begin
    rep_n   = '0;
    first_n = 1'b1;
    if (state == HELD && state_n == HELD) begin
      if (rep_hit) begin
        first_n = 1'b0;
      end else begin
        rep_n   = (&rep_cnt) ? rep_cnt : rep_cnt + 1'b1;
        first_n = rep_first;
      end
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_n;
      rep_first <= first_n;
    end
  end
`endif

  always_comb begin
    state_n = state;
    row_n   = row_q;
    col_n   = col_q;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (scan_en) begin
          state_n = SCAN;
          row_n   = 2'd0;
          cnt_n   = '0;
        end
      end
      SCAN: begin
        if (cnt >= CW'(SETTLE_CYC - 1)) begin
          cnt_n = '0;
          if (any_low) begin
            state_n = DEB_PRESS;
            col_n   = hit_col;
            cnt_n   = CW'(1);
          end else begin
            row_n = row_nxt;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DEB_PRESS: begin
        if (!cur_low) begin
          state_n = SCAN;
          row_n   = row_nxt;
          cnt_n   = '0;
        end else if (cnt >= CW'(DEBOUNCE_CYC - 1)) begin
          state_n = HELD;
          cnt_n   = '0;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HELD: begin
        if (!cur_low) begin
          state_n = DEB_REL;
          cnt_n   = CW'(1);
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_hit) begin
          accept = 1'b1;
        end
`endif
      end
      DEB_REL: begin
        if (cur_low) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt >= CW'(DEBOUNCE_CYC - 1)) begin
          state_n = SCAN;
          row_n   = row_nxt;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    // Losing scan permission aborts any press in flight.
    if (!scan_en) begin
      state_n = IDLE;
      row_n   = 2'd0;
      cnt_n   = '0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row_q <= 2'd0;
      col_q <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      row_q <= row_n;
      col_q <= col_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      key_code    <= KEY_NONE;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (accept && (!key_valid || key_ack)) begin
        key_code  <= key_encode(row_q, col_q);
        key_valid <= 1'b1;
      end else if (accept) begin
        key_overrun <= 1'b1;
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        key_code  <= KEY_NONE;
      end
    end
  end

  assign drive     = (state != IDLE);
  assign keypad_r1 = !(drive && row_q == 2'd0);
  assign keypad_r2 = !(drive && row_q == 2'd1);
  assign keypad_r3 = !(drive && row_q == 2'd2);
  assign key_held  = (state == HELD) || (state == DEB_REL);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 3x3 key matrix.
// Build with KEYPAD_AUTOREPEAT_EN to cover the repeat timing.
module tb_keypad_scan_ctrl;

  logic       hwclk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic       keypad_r1, keypad_r2, keypad_r3;
  logic       keypad_c1, keypad_c2, keypad_c3;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_overrun;

  int  krow = 0;
  int  kcol = 0;
  bit  kdown = 1'b0;
  int  checks = 0;
  int  failures = 0;
  logic row_on;

  keypad_scan_ctrl #(
    .SETTLE_CYC     (4),
    .DEBOUNCE_CYC   (16),
    .REPEAT_DLY_CYC (64),
    .REPEAT_CYC     (32)
  ) dut (
    .hwclk       (hwclk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .keypad_r1   (keypad_r1),
    .keypad_r2   (keypad_r2),
    .keypad_r3   (keypad_r3),
    .keypad_c1   (keypad_c1),
    .keypad_c2   (keypad_c2),
    .keypad_c3   (keypad_c3),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  always #5 hwclk = ~hwclk;

  assign row_on = (krow == 0 && !keypad_r1) ||
                  (krow == 1 && !keypad_r2) ||
                  (krow == 2 && !keypad_r3);
  assign keypad_c1 = !(kdown && kcol == 0 && row_on);
  assign keypad_c2 = !(kdown && kcol == 1 && row_on);
  assign keypad_c3 = !(kdown && kcol == 2 && row_on);

  function automatic bit row_low(input int r);
    if (r == 0) return !keypad_r1;
    if (r == 1) return !keypad_r2;
    return !keypad_r3;
  endfunction

  function automatic logic [2:0] rows();
    return {keypad_r3, keypad_r2, keypad_r1};
  endfunction

  // Press while the row is idle, return at the first cycle it is driven.
  task automatic press_key(input int r, input int c, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (row_low(r) && n < 200) begin
      @(negedge hwclk);
      n++;
    end
    krow = r;
    kcol = c;
    kdown = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge hwclk);
      if (row_low(r)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge hwclk);
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rise(output int rise);
    rise = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge hwclk);
      if (key_valid) begin
        rise = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    scan_en = 1'b0;
    key_ack = 1'b0;
    kdown = 1'b0;
    repeat (3) @(negedge hwclk);
    checks++;
    if (rows() !== 3'b111) begin
      failures++;
      $display("FAIL reset_rows got=%b exp=111", rows());
    end
    checks++;
    if (key_code !== 4'd0 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_key got=%0d/%b exp=0/0", key_code, key_valid);
    end
    checks++;
    if (key_held !== 1'b0 || key_overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00", key_held, key_overrun);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge hwclk);
    checks++;
    if (rows() !== 3'b111) begin
      failures++;
      $display("FAIL idle_rows got=%b exp=111", rows());
    end
  endtask

  task automatic test_scan;
    logic [2:0] exp;
    scan_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge hwclk);
      exp = 3'b111;
      exp[(i / 4) % 3] = 1'b0;
      checks++;
      if (rows() !== exp || key_valid !== 1'b0) begin
        failures++;
        $display("FAIL scan_c%0d rows=%b v=%b exp=%b/0",
                 i, rows(), key_valid, exp);
      end
    end
  endtask

  task automatic test_press_ack;
    bit ok;
    int rise;
    int hi;
    bit quiet;
    press_key(1, 2, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL p6_row got=timeout exp=row1 low");
    end
    wait_rise(rise);
    checks++;
    if (rise !== 19) begin
      failures++;
      $display("FAIL p6_latency got=%0d exp=19", rise);
    end
    checks++;
    if (key_code !== 4'd6 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL p6_code got=%0d h=%b exp=6 h=1", key_code, key_held);
    end
    hi = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge hwclk);
      if (key_valid) hi++;
      if (i == 5) key_ack = 1'b1;
    end
    @(negedge hwclk);
    key_ack = 1'b0;
    if (key_valid) hi++;
    checks++;
    if (hi !== 6 || key_code !== 4'd0) begin
      failures++;
      $display("FAIL p6_ack got=%0d code=%0d exp=6 code=0", hi, key_code);
    end
    repeat (15) @(negedge hwclk);
    kdown = 1'b0;
    quiet = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge hwclk);
      if (key_valid || !key_held) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL p6_release got=early exp=held 17 cyc");
    end
    @(negedge hwclk);
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("FAIL p6_held_off got=%b exp=0", key_held);
    end
  endtask

  task automatic test_bounce;
    bit ok;
    int rise;
    press_key(1, 0, ok);
    repeat (8) @(negedge hwclk);
    kdown = 1'b0;
    @(negedge hwclk);
    kdown = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge hwclk);
      if (!row_low(1)) begin
        ok = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 200; i++) begin
      if (row_low(1)) break;
      @(negedge hwclk);
    end
    wait_rise(rise);
    checks++;
    if (rise !== 19 || key_code !== 4'd4 || !ok) begin
      failures++;
      $display("FAIL bounce got=%0d code=%0d exp=19 code=4",
               rise, key_code);
    end
    key_ack = 1'b1;
    @(negedge hwclk);
    key_ack = 1'b0;
    kdown = 1'b0;
    wait_held_low(ok);
    checks++;
    if (!ok || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL bounce_end got=held%b v=%b exp=0/0",
               key_held, key_valid);
    end
  endtask

  task automatic test_overrun;
    bit ok;
    int rise;
    int pulses;
    press_key(0, 0, ok);
    wait_rise(rise);
    checks++;
    if (rise !== 19 || key_code !== 4'd1) begin
      failures++;
      $display("FAIL ov_first got=%0d code=%0d exp=19 code=1",
               rise, key_code);
    end
    kdown = 1'b0;
    wait_held_low(ok);
    press_key(2, 2, ok);
    rise = -1;
    pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge hwclk);
      if (key_overrun) begin
        pulses++;
        if (rise < 0) rise = n;
      end
    end
    checks++;
    if (rise !== 19 || pulses !== 1) begin
      failures++;
      $display("FAIL ov_pulse got=at%0d x%0d exp=at19 x1", rise, pulses);
    end
    checks++;
    if (key_code !== 4'd1 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL ov_keep got=%0d/%b exp=1/1", key_code, key_valid);
    end
    key_ack = 1'b1;
    @(negedge hwclk);
    key_ack = 1'b0;
    checks++;
    if (key_code !== 4'd0 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL ov_ack got=%0d/%b exp=0/0", key_code, key_valid);
    end
    kdown = 1'b0;
    wait_held_low(ok);
  endtask

  task automatic test_scan_en;
    bit ok;
    bit quiet;
    press_key(1, 1, ok);
    repeat (8) @(negedge hwclk);
    scan_en = 1'b0;
    @(negedge hwclk);
    checks++;
    if (rows() !== 3'b111 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL en_off got=%b h=%b exp=111 h=0", rows(), key_held);
    end
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge hwclk);
      if (key_valid || rows() !== 3'b111) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL en_quiet got=activity exp=none");
    end
    kdown = 1'b0;
    repeat (3) @(negedge hwclk);
    scan_en = 1'b1;
    @(negedge hwclk);
    checks++;
    if (rows() !== 3'b110) begin
      failures++;
      $display("FAIL en_restart got=%b exp=110", rows());
    end
  endtask

  task automatic test_reset_held;
    bit ok;
    int rise;
    press_key(1, 1, ok);
    wait_rise(rise);
    repeat (3) @(negedge hwclk);
    checks++;
    if (key_held !== 1'b1 || key_code !== 4'd5) begin
      failures++;
      $display("FAIL rh_pre got=h%b code=%0d exp=h1 code=5",
               key_held, key_code);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rows() !== 3'b111 || key_valid !== 1'b0 ||
        key_code !== 4'd0 || key_held !== 1'b0 ||
        key_overrun !== 1'b0) begin
      failures++;
      $display("FAIL rh_reset got=%b v%b c%0d h%b exp=111 v0 c0 h0",
               rows(), key_valid, key_code, key_held);
    end
    kdown = 1'b0;
    repeat (2) @(negedge hwclk);
    rst_n = 1'b1;
  endtask

  task automatic test_hold_long;
    bit ok;
    int rise;
    int rises[$];
    int exp[$];
    int last;
    bit prev;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp = '{64, 96, 128};
`endif
    press_key(1, 1, ok);
    wait_rise(rise);
    checks++;
    if (rise !== 19 || key_code !== 4'd5) begin
      failures++;
      $display("FAIL hl_first got=%0d code=%0d exp=19 code=5",
               rise, key_code);
    end
    last = 0;
    prev = 1'b1;
    for (int c = 1; c <= 131; c++) begin
      @(negedge hwclk);
      key_ack = 1'b0;
      if (key_valid && !prev) begin
        rises.push_back(c);
        last = c;
      end
      prev = key_valid;
      if (key_valid && c == last + 5) key_ack = 1'b1;
    end
    kdown = 1'b0;
    key_ack = key_valid;
    @(negedge hwclk);
    key_ack = 1'b0;
    checks++;
    if (rises.size() !== exp.size()) begin
      failures++;
      $display("FAIL hl_count got=%0d exp=%0d", rises.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (rises[i] !== exp[i]) begin
          failures++;
          $display("FAIL hl_rep%0d got=%0d exp=%0d", i, rises[i], exp[i]);
        end
      end
    end
    wait_held_low(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hl_release got=held exp=released");
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press_ack();
    test_bounce();
    test_overrun();
    test_scan_en();
    test_reset_held();
    test_hold_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
